// File: rtl/draw_ball_pipe.sv
// draw_ball_pipe: 3-stage N-ball circle renderer with per-frame shadowing and overlap flag (optional rim shading via DRAW_BALL_SHADE_EN)
module draw_ball_pipe #(
  parameter int BALL_NUM = 4,
  parameter int RAD_W    = 6,
  parameter int IDX_W    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     frame_start,
  input  logic [11:0]              hcounter,
  input  logic [10:0]              vcounter,
  input  logic                     visible,
  input  logic [BALL_NUM*10-1:0]   xs,
  input  logic [BALL_NUM*10-1:0]   ys,
  input  logic [BALL_NUM-1:0]      active,
  input  logic [RAD_W-1:0]         radius,
  output logic [3:0]               out,
  output logic                     hit,
  output logic [IDX_W-1:0]         hit_idx,
  output logic                     overlap
);
  logic [BALL_NUM*10-1:0] xs_sh, ys_sh;
  logic [BALL_NUM-1:0]    active_sh, act_1, act_2, in_v;
  logic [RAD_W-1:0]       rad_sh;
  logic [2*RAD_W-1:0]     rad_x, r2_1, r2_2;
  logic signed [12:0]     dx_1 [BALL_NUM];
  logic signed [12:0]     dy_1 [BALL_NUM];
  logic [26:0]            d2_n [BALL_NUM];
  logic [26:0]            d2_2 [BALL_NUM];
  logic                   vis_1, vis_2, hit_n, multi, acc;
  logic [IDX_W-1:0]       idx_n;
  logic [3:0]             out_n;
`ifdef DRAW_BALL_SHADE_EN
  logic [RAD_W-1:0]       rad_m;
  logic [2*RAD_W-1:0]     rad_mx, rr2_1, rr2_2;
  logic [26:0]            wd2;
  assign rad_m  = (rad_sh == '0) ? '0 : rad_sh - RAD_W'(1);
  assign rad_mx = (2*RAD_W)'(rad_m);
`endif
  assign rad_x = (2*RAD_W)'(rad_sh);
  // squares are taken at full 27-bit width so off-screen distances never alias
  for (genvar i = 0; i < BALL_NUM; i++) begin : g_sq
    logic signed [26:0] ex, ey;
    assign ex      = 27'(dx_1[i]);
    assign ey      = 27'(dy_1[i]);
    assign d2_n[i] = ex * ex + ey * ey;
  end
  always_comb begin
    in_v  = '0;
    idx_n = '0;
`ifdef DRAW_BALL_SHADE_EN
    wd2   = '0;
`endif
    for (int i = BALL_NUM - 1; i >= 0; i--) begin
      in_v[i] = act_2[i] & vis_2 & (d2_2[i] <= 27'(r2_2));
      if (in_v[i]) begin
        idx_n = IDX_W'(i);
`ifdef DRAW_BALL_SHADE_EN
        wd2   = d2_2[i];
`endif
      end
    end
  end
  assign hit_n = |in_v;
  assign multi = |(in_v & (in_v - BALL_NUM'(1)));
`ifdef DRAW_BALL_SHADE_EN
  assign out_n = !hit_n ? 4'h0 : (wd2 <= 27'(rr2_2)) ? 4'hF : 4'h8;
`else
  assign out_n = hit_n ? 4'hF : 4'h0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      xs_sh     <= '0;
      ys_sh     <= '0;
      active_sh <= '0;
      rad_sh    <= '0;
      act_1     <= '0;
      act_2     <= '0;
      vis_1     <= 1'b0;
      vis_2     <= 1'b0;
      r2_1      <= '0;
      r2_2      <= '0;
      dx_1      <= '{default: '0};
      dy_1      <= '{default: '0};
      d2_2      <= '{default: '0};
`ifdef DRAW_BALL_SHADE_EN
      rr2_1     <= '0;
      rr2_2     <= '0;
`endif
      out       <= '0;
      hit       <= 1'b0;
      hit_idx   <= '0;
      overlap   <= 1'b0;
      acc       <= 1'b0;
    end else begin
      if (frame_start) begin
        xs_sh     <= xs;
        ys_sh     <= ys;
        active_sh <= active;
        rad_sh    <= radius;
      end
      vis_1 <= visible;
      act_1 <= active_sh;
      r2_1  <= rad_x * rad_x;
      for (int i = 0; i < BALL_NUM; i++) begin
        dx_1[i] <= $signed({1'b0, hcounter}) - $signed({3'b0, xs_sh[i*10+:10]});
        dy_1[i] <= $signed({2'b0, vcounter}) - $signed({3'b0, ys_sh[i*10+:10]});
      end
      vis_2 <= vis_1;
      act_2 <= act_1;
      r2_2  <= r2_1;
      d2_2  <= d2_n;
`ifdef DRAW_BALL_SHADE_EN
      rr2_1 <= rad_mx * rad_mx;
      rr2_2 <= rr2_1;
`endif
      out     <= out_n;
      hit     <= hit_n;
      hit_idx <= idx_n;
      overlap <= frame_start ? (acc | multi) : overlap;
      acc     <= frame_start ? 1'b0 : (acc | multi);
    end
  end
endmodule
